// File: rtl/mux_read_arbiter_if.sv
// Request/sample bundle between mux_read_arbiter, its requesters and modified_mux.
interface mux_read_arbiter_if;
  logic        en;
  logic [15:0] req;
  logic        mux_out;
  logic [3:0]  sel;
  logic [15:0] ack;
  logic        sample_valid;
  logic        sample_data;
  logic [3:0]  sample_ch;
  logic        busy;

  modport master (
    output en, req, mux_out,
    input  sel, ack, sample_valid, sample_data, sample_ch, busy
  );

  modport slave (
    input  en, req, mux_out,
    output sel, ack, sample_valid, sample_data, sample_ch, busy
  );
endinterface

// File: rtl/mux_read_arbiter.sv
// Round-robin arbiter sharing a LATENCY-deep pipelined 16:1 bit mux among 16
// requesters; a tag pipeline tracks which channel each mux sample belongs to.
module mux_read_arbiter #(
  parameter int unsigned LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  mux_read_arbiter_if.slave bus
);

  logic [3:0]  ptr_q, ptr_d;
  logic [3:0]  sel_q, sel_d;
  logic [15:0] pending_q, pending_d;
  logic [15:0] elig;
  logic        grant_v;
  logic [3:0]  grant_ch;
  logic [3:0]  idx;

  logic        tag_v_q  [LATENCY+1];
  logic [3:0]  tag_ch_q [LATENCY+1];
  logic        dlv_v;
  logic [3:0]  dlv_ch;

  logic [15:0] ack_q, ack_d;
  logic        sample_valid_q;
  logic        sample_data_q;
  logic [3:0]  sample_ch_q;

  // Rotating priority search starting at ptr; first eligible channel wins.
  always_comb begin
    elig     = bus.en ? (bus.req & ~pending_q) : '0;
    grant_v  = 1'b0;
    grant_ch = ptr_q;
    idx      = ptr_q;
    for (int unsigned i = 0; i < 16; i++) begin
      idx = ptr_q + 4'(i);
      if (!grant_v && elig[idx]) begin
        grant_v  = 1'b1;
        grant_ch = idx;
      end
    end
  end

  assign dlv_v  = tag_v_q[LATENCY];
  assign dlv_ch = tag_ch_q[LATENCY];

  // Clear before set so a same-edge grant of the delivered channel wins.
  always_comb begin
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    pending_d = pending_q;
    ack_d     = '0;
    if (dlv_v) begin
      pending_d[dlv_ch] = 1'b0;
      ack_d             = 16'd1 << dlv_ch;
    end
    if (grant_v) begin
      sel_d               = grant_ch;
      ptr_d               = grant_ch + 4'd1;
      pending_d[grant_ch] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q          <= '0;
      sel_q          <= '0;
      pending_q      <= '0;
      ack_q          <= '0;
      sample_valid_q <= 1'b0;
      sample_data_q  <= 1'b0;
      sample_ch_q    <= '0;
      for (int unsigned s = 0; s <= LATENCY; s++) begin
        tag_v_q[s]  <= 1'b0;
        tag_ch_q[s] <= '0;
      end
    end else begin
      assert (!(grant_v && dlv_v && (grant_ch == dlv_ch)));
      ptr_q          <= ptr_d;
      sel_q          <= sel_d;
      pending_q      <= pending_d;
      ack_q          <= ack_d;
      sample_valid_q <= dlv_v;
      tag_v_q[0]     <= grant_v;
      tag_ch_q[0]    <= grant_ch;
      for (int unsigned s = 1; s <= LATENCY; s++) begin
        tag_v_q[s]  <= tag_v_q[s-1];
        tag_ch_q[s] <= tag_ch_q[s-1];
      end
      if (dlv_v) begin
        sample_data_q <= bus.mux_out;
        sample_ch_q   <= dlv_ch;
      end
    end
  end

  assign bus.sel          = sel_q;
  assign bus.ack          = ack_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.sample_data  = sample_data_q;
  assign bus.sample_ch    = sample_ch_q;
  assign bus.busy         = |pending_q;

endmodule

// File: doc/mux_read_arbiter.md
# mux_read_arbiter

Round-robin read arbiter that shares the pipelined 16:1 bit multiplexer (`modified_mux`) among 16 requesters. It drives the mux select, tracks which channel is in flight through the mux pipeline, and returns each sampled bit to its requester with a one-cycle acknowledge pulse. It sits directly in front of `modified_mux`: `sel` connects to the mux `sel`, and the mux `out` feeds back on `mux_out`.

## Interface

- `LATENCY`, default 1: number of clock edges from a `sel` change to a valid `mux_out`. Equals the mux pipeline depth. Legal range is 1 or more.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: when high, new grants are allowed. When low, no new grants are issued and in-flight reads drain normally.
- `req` input [15:0]: level request per channel. Channel k reads mux input `in[k+1]`.
- `mux_out` input 1: the `out` of `modified_mux`.
- `sel` output [3:0]: registered select to the mux; holds its last value while idle.
- `ack` output [15:0]: one-hot, single-cycle pulse marking sample delivery to channel k.
- `sample_valid` output 1: high for one cycle with each `ack` pulse.
- `sample_data` output 1: sampled bit; valid only while `sample_valid` is high.
- `sample_ch` output [3:0]: channel index of the current sample.
- `busy` output 1: high while any read is in flight (OR of `pending`).

## Operation

- **State:**
  - `ptr[3:0]`: round-robin start pointer.
  - `pending[15:0]`: channels granted but not yet acked.
  - Tag pipeline: LATENCY+1 stages of {valid, ch[3:0]}.
- **Eligibility:** `elig = req & ~pending`, and no channel is eligible when `en` is low.
- **Arbitration:** the winner is the first set bit of `elig`, searching ptr, ptr+1, … , 15, 0, … , ptr−1. At most one grant is issued per cycle.
- **On a grant at a clock edge:**
  - `sel` is set to the winner.
  - `pending[winner]` is set.
  - `ptr` becomes (winner+1) mod 16, wrapping 15 to 0.
  - {1, winner} enters stage 0 of the tag pipeline.
- **With no grant:** `sel` and `ptr` are unchanged, and {0, x} enters the tag pipeline.
- **Delivery:** when the last tag stage holds valid channel c at a clock edge:
  - `sample_data` captures `mux_out`.
  - `sample_ch` is set to c.
  - `sample_valid` is set to 1.
  - `ack` is set to one-hot(c).
  - `pending[c]` is cleared.
  - When the last stage is invalid, `sample_valid` and `ack` return to 0, and `sample_data` and `sample_ch` hold their values.
- **Requester rule:** a requester lowers `req` in the cycle its `ack` is high unless it wants another sample. If `req` is still high during the ack cycle, that is a new request.
- **Same-edge set and clear:** if `pending[c]` is cleared and channel c is granted at the same edge, the grant wins. This case cannot occur with the required masking, and the design must assert against it in simulation.

## Timing

- **Reset values:** `sel`=0, `ack`=0, `sample_valid`=0, `sample_data`=0, `sample_ch`=0, `busy`=0, `ptr`=0, `pending`=0, all tags invalid.
- **Reset mid-operation:** in-flight reads are discarded with no ack. The mux pipeline contents are ignored because all tags are invalid.
- **Grant-to-ack latency:** the grant is made at edge E0; `ack` and `sample_valid` are high in the cycle after edge E0+LATENCY+1. With LATENCY=1, ack appears 2 edges after the grant.
- **Throughput:** one grant per cycle across distinct channels. A single channel can be granted at most once every LATENCY+2 cycles.
- **Fairness:** with all 16 channels requesting continuously, each channel is granted exactly once per 16 consecutive grants.
- **`en` low:** `busy` falls in the cycle after the last ack edge.
- **Data contract:** `sample_data` must equal the value of mux input `in[c+1]` at the edge where `sel`=c was captured into the mux pipeline.

## Test plan

- **Single request:** `req`=0x0020 held until ack, `in[6]`=1 → `sel`=5 one cycle after the grant edge; `ack`=0x0020, `sample_ch`=5 and `sample_data`=1 exactly LATENCY+1 edges after the grant; `busy` high for 2 cycles.
- **Round-robin order:** `req`=0x8001 held continuously, `ptr`=0 → grants alternate 0, 15, 0, 15; there are no back-to-back grants to one channel; each channel gets one ack per LATENCY+2 cycles.
- **Full load with wrap:** all 16 requesting continuously, `in`=0xA5C3 → 16 consecutive grants in order 0…15, then the sequence wraps to 0; every `sample_data` matches its bit of `in`; there are no idle cycles after the pipeline fills.
- **`en` drop:** `req`=0xFFFF, drop `en` after 3 grants → exactly 3 acks follow, then no further grants; `busy`=0 one cycle after the last ack.
- **Reset mid-flight:** assert `rst` one cycle after the grant of channel 9 → no ack for channel 9; all outputs return to reset values; after `rst` falls with `req`=0x0200 still high, channel 9 is re-granted and acked normally.
- **Back-to-back same channel:** `req[3]` held through its ack → channel 3 is re-granted on the edge that ends the ack cycle, with an exact 3-cycle period when LATENCY=1.
